// File: rtl/event_slot_encoder.sv
// event_slot_encoder: stamps each rising edge of event_in with the current slot count into a FWFT FIFO
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   enable     - advances the slot counter and allows event capture
//   event_in   - event line, rising edges are captured
//   slot       - current slot counter value (registered)
//   code_out   - slot code at the FIFO head, valid while code_valid=1
//   code_valid - FIFO not empty
//   code_ready - consumer accept, pops the head when code_valid=1
//   overflow   - sticky, a capture was dropped on a full FIFO
//   fill       - FIFO occupancy 0..DEPTH
module event_slot_encoder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     event_in,
    output logic [WIDTH-1:0]         slot,
    output logic [WIDTH-1:0]         code_out,
    output logic                     code_valid,
    input  logic                     code_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] slot_q, slot_d;
    logic             event_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      fill_q, fill_d;
    logic             ovf_q;
    logic             push_req, full, pop, push;
    always_comb begin
        push_req = event_in & ~event_q & enable;
        full     = fill_q == (AW+1)'(DEPTH);
        pop      = (fill_q != '0) & code_ready;
        // a pop frees the slot at the same edge, so a full FIFO still accepts the push
        push     = push_req & (~full | pop);
        slot_d   = enable ? slot_q + WIDTH'(1) : slot_q;
        fill_d   = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            event_q <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            event_q <= event_in;
            fill_q  <= fill_d;
            // the stored code is the slot value before this edge's increment
            if (push) begin
                mem_q[wr_q] <= slot_q;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            if (push_req & full & ~pop) ovf_q <= 1'b1;
        end
    end
    assign slot       = slot_q;
    assign code_out   = mem_q[rd_q];
    assign code_valid = fill_q != '0;
    assign overflow   = ovf_q;
    assign fill       = fill_q;
endmodule

// File: doc/event_slot_encoder.md
EVENT_SLOT_ENCODER -- requirements
Module: event_slot_encoder

Interface
REQ-001 Parameter WIDTH, default 4, sets the width of the slot counter and of the codes.
REQ-002 Parameter DEPTH, default 4, sets the number of entries in the code FIFO; it is a power of 2 and at least 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 enable  input  1  high lets the slot counter advance and lets events be captured.
REQ-006 event_in  input  1  event line; each rising edge is encoded as a slot code.
REQ-007 slot  output  WIDTH  current slot counter value, driven from a register.
REQ-008 code_out  output  WIDTH  slot code at the FIFO head; valid only while code_valid=1.
REQ-009 code_valid  output  1  high while the FIFO is not empty.
REQ-010 code_ready  input  1  consumer accept; a pop happens on any edge where code_valid=1 and code_ready=1.
REQ-011 overflow  output  1  sticky flag: a captured code was dropped because the FIFO was full.
REQ-012 fill  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-013 Slot counter: increments by 1 on every edge where enable=1, and holds while enable=0.
REQ-014 Slot counter wraps modulo 2^WIDTH: 2^WIDTH-1 -> 0, with no flag raised.
REQ-015 Edge detect: event_q is a register updated with event_in on every edge, regardless of enable.
REQ-016 A rise is event_in=1 and event_q=0, sampled at the same edge.
REQ-017 Capture: a rise sampled at an edge while enable=1 generates a push of the value slot held before that edge.
REQ-018 The pushed value does not include the increment performed at the same edge.
REQ-019 A rise sampled while enable=0 is discarded and does not set overflow.
REQ-020 Holding event_in high generates exactly one capture; the next capture requires event_in to go low for at least one cycle.
REQ-021 FIFO ordering: the FIFO is first-word-fall-through, so code_out is the oldest stored entry.
REQ-022 While the FIFO is empty, code_out holds its last value; no checker relies on it.
REQ-023 Latency: when a push enters an empty FIFO at edge N, code_valid=1 and code_out equals the pushed code immediately after edge N.
REQ-024 Pop: when code_valid=1 and code_ready=1 at an edge, the head entry is removed at that edge.
REQ-025 code_ready is ignored while code_valid=0; a pop on an empty FIFO causes no state change.
REQ-026 Push and pop at the same edge with 0 < fill < DEPTH: both take effect and fill is unchanged.
REQ-027 Push and pop at the same edge with fill=DEPTH: both take effect, the new code is stored, fill stays DEPTH and overflow is not set.
REQ-028 Push at the same edge as fill=0 with code_ready=1: the push takes effect, nothing is popped and fill becomes 1.
REQ-029 Push with no pop while fill=DEPTH: the new code is dropped and the FIFO contents are unchanged.
REQ-030 In the case of REQ-029, overflow is set to 1 after that edge.
REQ-031 overflow clears only on rst.
REQ-032 Read and write pointers wrap modulo DEPTH.
REQ-033 fill is always equal to (pushes accepted) - (pops) since reset.

Reset
REQ-034 While rst=1 at an edge: slot=0, event_q=0, FIFO emptied (fill=0, code_valid=0), overflow=0 and both pointers=0.
REQ-035 During a reset cycle, rst overrides enable, event_in and code_ready.
REQ-036 Any entries not yet popped when reset occurs are lost.
REQ-037 After reset event_q=0, so event_in=1 at the first edge after rst falls is a rise.
REQ-038 If enable=1 at that first edge, the rise captures code 0.

Verification
REQ-039 Counter wrap: WIDTH=4, enable=1, rst released for 20 cycles -> slot sequence 0..15,0,1,2,3, with no FIFO activity.
REQ-040 Single capture: event_in pulses high for 1 cycle when slot=5 and code_ready=0 -> code_valid=1 with code_out=5 after that edge, and fill=1.
REQ-041 Level versus edge: event_in rises when slot=3 and stays high for 6 cycles, code_ready=0 -> exactly one entry, code_out=3, fill=1.
REQ-042 Overflow: code_ready=0 and 5 separate rises at slots 1,3,5,7,9 -> codes 1,3,5,7 kept and 9 dropped, overflow=1, fill=4.
REQ-043 Overflow drain: after REQ-042, hold code_ready=1 -> codes pop in order 1,3,5,7, code_valid=0 after 4 edges, and overflow stays 1.
REQ-044 Full with simultaneous push and pop: fill=4, code_ready=1, rise at slot 12 -> head popped, 12 stored at the tail, fill=4 and overflow=0.
REQ-045 Reset mid-operation: fill=3 and rst=1 for 1 cycle -> fill=0, code_valid=0, overflow=0 and slot=0.
REQ-046 Event right after reset: event_in held high through and after the reset cycle, with enable=1 -> code 0 is captured at the first edge after rst falls.
